therm_scan_conv: RTL and testbench

THERM_SCAN_CONV -- requirements
Module: therm_scan_conv

---
 rtl/therm_scan_conv.sv | 183 ++++++++++++++++++
 tb/tb_therm_scan_conv.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/therm_scan_conv.sv
// Multi-channel thermistor scan converter: ADC code to degC with linear scaling,
// per-channel exponential averaging and hysteretic high/low alarms.
module therm_scan_conv #(
    parameter int          NUM_CH   = 4,
    parameter int          ADC_W    = 10,
    parameter int          TEMP_W   = 12,
    parameter int unsigned GAIN     = 1,
    parameter int          SHIFT    = 2,
    parameter int          OFFSET   = -50,
    parameter int          AVG_LOG2 = 2,
    parameter int          CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [ADC_W-1:0]    in_code,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_W-1:0]     out_ch,
    output logic [TEMP_W-1:0]   out_temp,
    input  logic [TEMP_W-1:0]   thr_hi,
    input  logic [TEMP_W-1:0]   thr_lo,
    input  logic [TEMP_W-1:0]   hyst,
    output logic [NUM_CH-1:0]   alarm_hi,
    output logic [NUM_CH-1:0]   alarm_lo,
    output logic                err_ch
);

    localparam int PROD_W = ADC_W + 34;
    localparam int EXT_W  = TEMP_W + 2;
    localparam logic signed [PROD_W-1:0] T_MAX = PROD_W'((64'sd1 <<< (TEMP_W - 1)) - 64'sd1);
    localparam logic signed [PROD_W-1:0] T_MIN = -T_MAX - PROD_W'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, AVG = 2'd2, OUT = 2'd3} state_t;

    state_t                     state_r, state_s;
    logic                       in_ready_r, out_valid_r, err_ch_r, drop_r;
    logic [CH_W-1:0]            ch_r, out_ch_r;
    logic [ADC_W-1:0]           code_r;
    logic signed [TEMP_W-1:0]   raw_r, out_temp_r;
    logic signed [TEMP_W-1:0]   avg_r [NUM_CH];
    logic [NUM_CH-1:0]          init_r, alarm_hi_r, alarm_lo_r;

    logic                       accept_s, ch_bad_s;
    logic signed [PROD_W-1:0]   prod_s, raw_full_s;
    logic signed [TEMP_W-1:0]   raw_sat_s, avg_cur_s, new_avg_s;
    logic signed [TEMP_W:0]     diff_s, step_s, sum_s;
    logic signed [EXT_W-1:0]    avg_ext_s, thr_hi_ext_s, thr_lo_ext_s, hyst_ext_s;
    logic                       hi_set_s, hi_clr_s, lo_set_s, lo_clr_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_ch    = out_ch_r;
    assign out_temp  = out_temp_r;
    assign alarm_hi  = alarm_hi_r;
    assign alarm_lo  = alarm_lo_r;
    assign err_ch    = err_ch_r;

    assign accept_s = in_valid & in_ready_r;
    assign ch_bad_s = ({1'b0, in_ch} >= (CH_W + 1)'(NUM_CH));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a dropped sample leaves CONV straight back to IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = CONV;
                else          state_s = IDLE;
            end
            CONV: begin
                if (drop_r) state_s = IDLE;
                else        state_s = AVG;
            end
            AVG:  state_s = OUT;
            OUT: begin
                if (out_ready) state_s = IDLE;
                else           state_s = OUT;
            end
            default: state_s = IDLE;
        endcase
    end

    // Scale, shift and offset at full width, then clamp to the temperature range
    always_comb begin
        prod_s     = $signed({{(PROD_W - ADC_W){1'b0}}, code_r}) * $signed(PROD_W'(GAIN));
        raw_full_s = (prod_s >>> SHIFT) + $signed(PROD_W'(OFFSET));
        if (raw_full_s > T_MAX) begin
            raw_sat_s = T_MAX[TEMP_W-1:0];
        end else if (raw_full_s < T_MIN) begin
            raw_sat_s = T_MIN[TEMP_W-1:0];
        end else begin
            raw_sat_s = raw_full_s[TEMP_W-1:0];
        end
    end

    // Exponential average; the step never overshoots raw, so no clamp is needed
    always_comb begin
        avg_cur_s = avg_r[ch_r];
        diff_s    = {raw_r[TEMP_W-1], raw_r} - {avg_cur_s[TEMP_W-1], avg_cur_s};
        step_s    = diff_s >>> AVG_LOG2;
        sum_s     = {avg_cur_s[TEMP_W-1], avg_cur_s} + step_s;
        if (init_r[ch_r]) begin
            new_avg_s = sum_s[TEMP_W-1:0];
        end else begin
            new_avg_s = raw_r;
        end
    end

    // Alarm threshold comparisons at widened signed precision
    always_comb begin
        avg_ext_s    = EXT_W'(new_avg_s);
        thr_hi_ext_s = EXT_W'($signed(thr_hi));
        thr_lo_ext_s = EXT_W'($signed(thr_lo));
        hyst_ext_s   = $signed({2'b00, hyst});
        hi_set_s     = (avg_ext_s > thr_hi_ext_s);
        hi_clr_s     = (avg_ext_s < (thr_hi_ext_s - hyst_ext_s));
        lo_set_s     = (avg_ext_s < thr_lo_ext_s);
        lo_clr_s     = (avg_ext_s > (thr_lo_ext_s + hyst_ext_s));
    end

    // Datapath, per-channel state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            err_ch_r    <= 1'b0;
            drop_r      <= 1'b0;
            ch_r        <= '0;
            out_ch_r    <= '0;
            code_r      <= '0;
            raw_r       <= '0;
            out_temp_r  <= '0;
            init_r      <= '0;
            alarm_hi_r  <= '0;
            alarm_lo_r  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                avg_r[i] <= '0;
            end
        end else begin
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == OUT);
            if (accept_s) begin
                ch_r   <= in_ch;
                code_r <= in_code;
                drop_r <= ch_bad_s;
                if (ch_bad_s) begin
                    err_ch_r <= 1'b1;
                end
            end
            if (state_r == CONV) begin
                raw_r <= raw_sat_s;
            end
            if (state_r == AVG) begin
                avg_r[ch_r]  <= new_avg_s;
                init_r[ch_r] <= 1'b1;
                out_temp_r   <= new_avg_s;
                out_ch_r     <= ch_r;
                if (hi_set_s) begin
                    alarm_hi_r[ch_r] <= 1'b1;
                end else if (hi_clr_s) begin
                    alarm_hi_r[ch_r] <= 1'b0;
                end
                if (lo_set_s) begin
                    alarm_lo_r[ch_r] <= 1'b1;
                end else if (lo_clr_s) begin
                    alarm_lo_r[ch_r] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_therm_scan_conv.sv
// Randomized self-checking bench for therm_scan_conv against a behavioural model.
module tb_therm_scan_conv;

    localparam int GAIN_M   = 1;
    localparam int SHIFT_M  = 2;
    localparam int OFFSET_M = -50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, err_ch;
    logic [1:0]  in_ch = 2'd0, out_ch;
    logic [9:0]  in_code = 10'd0;
    logic [11:0] out_temp;
    logic [11:0] thr_hi = 12'd0, thr_lo = 12'd0, hyst = 12'd0;
    logic [3:0]  alarm_hi, alarm_lo;

    logic        x_in_valid = 1'b0, x_out_ready = 1'b1;
    logic        x_in_ready, x_out_valid, x_err_ch;
    logic [2:0]  x_in_ch = 3'd0, x_out_ch;
    logic [9:0]  x_in_code = 10'd0;
    logic [11:0] x_out_temp;
    logic [5:0]  x_alarm_hi, x_alarm_lo;

    int n_checks = 0;
    int n_errors = 0;

    int th_hi_m, th_lo_m, hy_m;
    int avg_m [4];
    bit init_m [4];
    bit ahi_m [4];
    bit alo_m [4];

    always #5 clk = ~clk;

    therm_scan_conv dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_temp(out_temp), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .hyst(hyst), .alarm_hi(alarm_hi), .alarm_lo(alarm_lo), .err_ch(err_ch)
    );

    therm_scan_conv #(.NUM_CH(6), .GAIN(64), .OFFSET(-3000)) dut_x (
        .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready),
        .in_ch(x_in_ch), .in_code(x_in_code), .out_valid(x_out_valid), .out_ready(x_out_ready),
        .out_ch(x_out_ch), .out_temp(x_out_temp), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .hyst(hyst), .alarm_hi(x_alarm_hi), .alarm_lo(x_alarm_lo), .err_ch(x_err_ch)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_thr(input int hi, input int lo, input int hy);
        th_hi_m = hi; th_lo_m = lo; hy_m = hy;
        thr_hi = 12'(hi); thr_lo = 12'(lo); hyst = 12'(hy);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            avg_m[i] = 0; init_m[i] = 1'b0; ahi_m[i] = 1'b0; alo_m[i] = 1'b0;
        end
    endtask

    // Temperature from code: scale, floor-divide by 2^SHIFT, offset, clamp to 12-bit signed
    function automatic int conv_m(input int code);
        longint v;
        v = longint'(code) * GAIN_M;
        v = v >>> SHIFT_M;
        v = v + OFFSET_M;
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return int'(v);
    endfunction

    task automatic model_update(input int ch, input int code);
        int raw;
        raw = conv_m(code);
        if (!init_m[ch]) begin
            avg_m[ch] = raw;
            init_m[ch] = 1'b1;
        end else begin
            avg_m[ch] = avg_m[ch] + ((raw - avg_m[ch]) >>> 2);
        end
        if (avg_m[ch] > th_hi_m) ahi_m[ch] = 1'b1;
        else if (avg_m[ch] < th_hi_m - hy_m) ahi_m[ch] = 1'b0;
        if (avg_m[ch] < th_lo_m) alo_m[ch] = 1'b1;
        else if (avg_m[ch] > th_lo_m + hy_m) alo_m[ch] = 1'b0;
    endtask

    function automatic int pack_hi();
        int v = 0;
        for (int i = 0; i < 4; i++) if (ahi_m[i]) v += (1 << i);
        return v;
    endfunction

    function automatic int pack_lo();
        int v = 0;
        for (int i = 0; i < 4; i++) if (alo_m[i]) v += (1 << i);
        return v;
    endfunction

    // One full transaction; stall cycles hold out_ready low while in OUT
    task automatic do_sample(input int ch, input int code, input int stall);
        model_update(ch, code);
        check_eq("rdy_idle", int'(in_ready), 1);
        in_valid = 1'b1; in_ch = ch[1:0]; in_code = code[9:0];
        out_ready = (stall == 0);
        tick();
        in_ch = 2'($urandom_range(0, 3)); in_code = 10'($urandom_range(0, 1023));
        check_eq("rdy_conv", int'(in_ready), 0);
        check_eq("lat_conv", int'(out_valid), 0);
        tick();
        check_eq("lat_avg", int'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        check_eq("lat_out", int'(out_valid), 1);
        check_eq("rdy_out", int'(in_ready), 0);
        check_eq("out_ch", int'(out_ch), ch);
        check_eq("out_temp", int'($signed(out_temp)), avg_m[ch]);
        check_eq("alarm_hi", int'(alarm_hi), pack_hi());
        check_eq("alarm_lo", int'(alarm_lo), pack_lo());
        for (int k = 0; k < stall; k++) begin
            tick();
            check_eq("stall_valid", int'(out_valid), 1);
            check_eq("stall_ch", int'(out_ch), ch);
            check_eq("stall_temp", int'($signed(out_temp)), avg_m[ch]);
            check_eq("stall_rdy", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        check_eq("ret_rdy", int'(in_ready), 1);
        check_eq("ret_valid", int'(out_valid), 0);
    endtask

    task automatic x_sample(input int ch, input int code, input int exp);
        x_in_valid = 1'b1; x_in_ch = ch[2:0]; x_in_code = code[9:0];
        tick();
        x_in_valid = 1'b0;
        tick();
        tick();
        check_eq("x_valid", int'(x_out_valid), 1);
        check_eq("x_ch", int'(x_out_ch), ch);
        check_eq("x_temp", int'($signed(x_out_temp)), exp);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rdy"}, int'(in_ready), 0);
        check_eq({tag, "_valid"}, int'(out_valid), 0);
        check_eq({tag, "_ch"}, int'(out_ch), 0);
        check_eq({tag, "_temp"}, int'(out_temp), 0);
        check_eq({tag, "_ahi"}, int'(alarm_hi), 0);
        check_eq({tag, "_alo"}, int'(alarm_lo), 0);
        check_eq({tag, "_err"}, int'(err_ch), 0);
    endtask

    initial begin
        model_reset();
        set_thr(80, -100, 5);
        repeat (3) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();
        check_eq("rst_rdy1", int'(in_ready), 1);

        do_sample(0, 400, 0);
        check_eq("s1_temp", int'($signed(out_temp)), 50);
        do_sample(0, 600, 0);
        check_eq("s2_temp", int'($signed(out_temp)), 62);
        do_sample(1, 600, 0);
        check_eq("s2_ch1_temp", int'($signed(out_temp)), 100);
        check_eq("s3_ahi_set", int'(alarm_hi[1]), 1);
        for (int i = 0; i < 5; i++) do_sample(1, 300, 0);
        check_eq("s3_ahi_clr", int'(alarm_hi[1]), 0);

        do_sample(2, 500, 10);

        for (int i = 0; i < 48; i++) begin
            if (i % 8 == 0)
                set_thr(int'($urandom_range(0, 160)), int'($urandom_range(0, 80)) - 60,
                        int'($urandom_range(0, 20)));
            do_sample(int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)),
                      int'($urandom_range(0, 3)));
        end
        check_eq("main_err", int'(err_ch), 0);

        set_thr(80, -100, 5);
        x_sample(0, 1023, 2047);
        x_sample(1, 0, -2048);
        check_eq("x_ahi", int'(x_alarm_hi), 1);
        check_eq("x_alo", int'(x_alarm_lo), 2);
        check_eq("x_err0", int'(x_err_ch), 0);
        x_in_valid = 1'b1; x_in_ch = 3'd6; x_in_code = 10'd100;
        tick();
        x_in_valid = 1'b0;
        check_eq("x_err1", int'(x_err_ch), 1);
        for (int k = 0; k < 3; k++) begin
            check_eq("x_drop_valid", int'(x_out_valid), 0);
            tick();
        end
        check_eq("x_drop_rdy", int'(x_in_ready), 1);

        in_valid = 1'b1; in_ch = 2'd0; in_code = 10'd900; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        check_eq("midrst_xerr", int'(x_err_ch), 0);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("midrst_rdy1", int'(in_ready), 1);
        do_sample(0, 200, 0);
        check_eq("midrst_init", int'($signed(out_temp)), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
